// File: rtl/alu_ctrl_muldiv.sv
// ALU control decoder for the MIPS datapath with an iterative radix-2 multiply/divide
// sequencer (shift-add multiply, restoring divide) that owns the HI/LO registers.
module alu_ctrl_muldiv #(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 3,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic [1:0]         hilo_sel_o,
  output logic               stall_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);

  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'('h10);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'('h12);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'('h18);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'('h19);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'('h1A);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'('h1B);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'('h20);
  localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'('h21);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'('h22);
  localparam logic [FUNCT_W-1:0] F_SUBU  = FUNCT_W'('h23);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'('h24);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'('h25);
  localparam logic [FUNCT_W-1:0] F_NOR   = FUNCT_W'('h27);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'('h2A);

  localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] C_NOR = CTRL_W'(4'b1100);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  acc_hi, acc_lo;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic              neg_a, neg_b, is_mul;

  logic              is_rtype, is_muldiv, start, can_start;
  logic              start_signed, start_mul, start_neg_a, start_neg_b;
  logic [WIDTH-1:0]  start_mag_a, start_mag_b;

  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH+1:0]  div_diff;
  logic [WIDTH-1:0]  step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  res_hi, res_lo;

  // Decode
  always_comb begin
    ALUCtrl_o  = C_ADD;
    hilo_sel_o = 2'b00;
    case (ALUOp_i)
      OP_ADD: ALUCtrl_o = C_ADD;
      OP_SUB: ALUCtrl_o = C_SUB;
      OP_SLT: ALUCtrl_o = C_SLT;
      OP_OR:  ALUCtrl_o = C_OR;
      OP_RTYPE: begin
        case (funct_i)
          F_ADD, F_ADDU: ALUCtrl_o = C_ADD;
          F_SUB, F_SUBU: ALUCtrl_o = C_SUB;
          F_AND:         ALUCtrl_o = C_AND;
          F_OR:          ALUCtrl_o = C_OR;
          F_NOR:         ALUCtrl_o = C_NOR;
          F_SLT:         ALUCtrl_o = C_SLT;
          default:       ALUCtrl_o = C_ADD;
        endcase
        if (funct_i == F_MFHI) hilo_sel_o = 2'b01;
        if (funct_i == F_MFLO) hilo_sel_o = 2'b10;
      end
      default: ALUCtrl_o = C_ADD;
    endcase
  end

  // Start qualification and operand preparation
  always_comb begin
    is_rtype     = (ALUOp_i == OP_RTYPE);
    is_muldiv    = (funct_i == F_MULT) || (funct_i == F_MULTU) ||
                   (funct_i == F_DIV)  || (funct_i == F_DIVU);
    start        = valid_i && is_rtype && is_muldiv;
    can_start    = start && (state != BUSY);
    start_signed = (funct_i == F_MULT) || (funct_i == F_DIV);
    start_mul    = (funct_i == F_MULT) || (funct_i == F_MULTU);
    start_neg_a  = start_signed && src1_i[WIDTH-1];
    start_neg_b  = start_signed && src2_i[WIDTH-1];
    // An unsigned WIDTH-bit magnitude still represents 2^(WIDTH-1) exactly.
    start_mag_a  = start_neg_a ? -src1_i : src1_i;
    start_mag_b  = start_neg_b ? -src2_i : src2_i;
  end

  // One radix-2 step; acc_lo holds the multiplier or the dividend being shifted out.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    if (is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (div_diff[WIDTH+1]) begin
      step_hi = div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end else begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end
  end

  // Sign restoration applied to the final step's result
  always_comb begin
    prod   = {step_hi, step_lo};
    res_hi = step_hi;
    res_lo = step_lo;
    if (is_mul) begin
      if (neg_a ^ neg_b) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (mag_b == '0) begin
      res_lo = '1;
      res_hi = neg_a ? -mag_a : mag_a;
    end else begin
      res_lo = (neg_a ^ neg_b) ? -step_lo : step_lo;
      res_hi = neg_a ? -step_hi : step_hi;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = can_start ? BUSY : IDLE;
      BUSY:       if (cnt == CNT_LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    stall_o = start || (state == BUSY);
    done_o  = (state == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      is_mul <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      state <= state_nxt;
      if (state == BUSY) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          hi_o <= res_hi;
          lo_o <= res_lo;
        end
      end else if (can_start) begin
        mag_a  <= start_mag_a;
        mag_b  <= start_mag_b;
        neg_a  <= start_neg_a;
        neg_b  <= start_neg_b;
        is_mul <= start_mul;
        acc_hi <= '0;
        acc_lo <= start_mul ? start_mag_b : start_mag_a;
        cnt    <= '0;
      end
    end
  end

endmodule
